// File: rtl/serial_word_collector.sv
// serial_word_collector
//   Assembles N serial bits into a parallel word and hands it downstream with
//   a valid/ready handshake. Framing is continuous: once a frame is started,
//   every N accepted bits form one word until stop.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   start         begin a new frame (clears any partial word, latches dir)
//   stop          abort to IDLE, partial word discarded
//   dir           0: first bit lands in MSB, 1: first bit lands in LSB
//   bit_valid     bit_in is presented this cycle
//   bit_in        serial data
//   word_ready    downstream accepts word_out
//   clear_overrun clears the sticky overrun flag
//   word_out      assembled word (held stable while valid and not ready)
//   word_valid    word_out holds an unconsumed word
//   overrun       sticky: a completed word was dropped
//   busy          high while collecting
//   bit_count     bits accepted in the current word, 0..N-1
module serial_word_collector #(
  parameter  int N  = 4,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          dir,
  input  logic          bit_valid,
  input  logic          bit_in,
  input  logic          word_ready,
  input  logic          clear_overrun,
  output logic [N-1:0]  word_out,
  output logic          word_valid,
  output logic          overrun,
  output logic          busy,
  output logic [CW-1:0] bit_count
);

  generate
    if (N < 2) begin : g_bad_n
      $error("serial_word_collector: N must be at least 2");
    end
  endgenerate

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t       state;
  logic [N-1:0] sh;
  logic         dir_lat;

  logic         accept;
  logic         last_bit;
  logic         complete;
  logic         xfer;
  logic [N-1:0] next_sh;

  // start/stop in the same cycle take precedence over the bit
  assign accept   = (state == COLLECT) && bit_valid && !start && !stop;
  assign last_bit = (bit_count == CW'(N - 1));
  assign complete = accept && last_bit;
  assign xfer     = word_valid && word_ready;
  assign next_sh  = dir_lat ? {bit_in, sh[N-1:1]} : {sh[N-2:0], bit_in};
  assign busy     = (state == COLLECT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sh         <= '0;
      bit_count  <= '0;
      dir_lat    <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // framing path
      if (stop) begin
        state     <= IDLE;
        sh        <= '0;
        bit_count <= '0;
      end else if (start) begin
        state     <= COLLECT;
        sh        <= '0;
        bit_count <= '0;
        dir_lat   <= dir;
      end else if (accept) begin
        sh <= next_sh;
        if (last_bit) begin
          bit_count <= '0;
          dir_lat   <= dir;   // direction may change only on word boundaries
        end else begin
          bit_count <= bit_count + 1'b1;
        end
      end

      // output path: independent of start/stop so a pending word survives abort
      if (complete && (!word_valid || word_ready)) begin
        word_out   <= next_sh;
        word_valid <= 1'b1;
      end else if (xfer) begin
        word_valid <= 1'b0;
      end

      // set wins over clear
      if (complete && word_valid && !word_ready) overrun <= 1'b1;
      else if (clear_overrun)                    overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_word_collector.sv
module tb_serial_word_collector;

  localparam int N  = 8;
  localparam int CW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset, start, stop, dir, bit_valid, bit_in, word_ready, clear_overrun;
  logic [N-1:0]  word_out;
  logic          word_valid, overrun, busy;
  logic [CW-1:0] bit_count;

  int checks   = 0;
  int failures = 0;
  logic [N-1:0] exp_q[$];

  always #5 clk = ~clk;

  serial_word_collector #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir),
    .bit_valid(bit_valid), .bit_in(bit_in), .word_ready(word_ready),
    .clear_overrun(clear_overrun), .word_out(word_out), .word_valid(word_valid),
    .overrun(overrun), .busy(busy), .bit_count(bit_count)
  );

  function automatic logic [N-1:0] rev(input logic [N-1:0] w);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = w[N-1-i];
    return r;
  endfunction

  // One clock: scoreboard pops on every transfer seen at the negedge, then
  // the bench resumes 1 time unit after the rising edge.
  task automatic tick();
    logic [N-1:0] e;
    @(negedge clk);
    if (!reset && word_valid && word_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL xfer_unexpected: got word_out=%h, required no transfer", word_out);
      end else begin
        e = exp_q.pop_front();
        if (word_out !== e) begin
          failures++;
          $display("FAIL xfer_word: got %h, required %h", word_out, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; bit_valid = 0; bit_in = 0; clear_overrun = 0;
  endtask

  task automatic do_start(input logic d);
    dir = d; start = 1; bit_valid = 1; bit_in = 1;   // bit on start cycle must be ignored
    tick();
    start = 0; bit_valid = 0;
  endtask

  // Sends an N-bit sequence, first bit = seq[N-1]. Expected word is derived
  // from the frame direction the bench believes is latched.
  task automatic send_word(input logic [N-1:0] seq, input logic d_lat, input logic push);
    for (int i = 0; i < N; i++) begin
      bit_valid = 1; bit_in = seq[N-1-i];
      if (i == N - 1 && push) exp_q.push_back(d_lat ? rev(seq) : seq);
      tick();
    end
    bit_valid = 0;
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1; bit_in = 1'($urandom);
      tick();
    end
    bit_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      {start, stop, dir, bit_valid, bit_in, word_ready, clear_overrun} = 7'($urandom);
      tick();
    end
    checks++; if (word_out !== '0)   begin failures++; $display("FAIL rst_word_out: got %h, required 00", word_out); end
    checks++; if (word_valid !== 0)  begin failures++; $display("FAIL rst_word_valid: got %b, required 0", word_valid); end
    checks++; if (overrun !== 0)     begin failures++; $display("FAIL rst_overrun: got %b, required 0", overrun); end
    checks++; if (busy !== 0)        begin failures++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (bit_count !== '0)  begin failures++; $display("FAIL rst_bit_count: got %0d, required 0", bit_count); end
    reset = 0; idle_inputs(); word_ready = 1; dir = 0;
    tick();
  endtask

  task automatic test_shift_left();
    word_ready = 1;
    do_start(1'b0);
    checks++; if (busy !== 1) begin failures++; $display("FAIL left_busy: got %b, required 1", busy); end
    checks++; if (bit_count !== '0) begin failures++; $display("FAIL left_start_count: got %0d, required 0", bit_count); end
    send_word(8'hB2, 1'b0, 1'b1);
    checks++; if (word_out !== 8'hB2) begin failures++; $display("FAIL left_word: got %h, required b2", word_out); end
    checks++; if (word_valid !== 1) begin failures++; $display("FAIL left_valid: got %b, required 1", word_valid); end
    checks++; if (bit_count !== '0) begin failures++; $display("FAIL left_count_wrap: got %0d, required 0", bit_count); end
    tick();
    checks++; if (word_valid !== 0) begin failures++; $display("FAIL left_valid_1cyc: got %b, required 0", word_valid); end
    stop = 1; tick(); stop = 0;
  endtask

  task automatic test_shift_right();
    word_ready = 1;
    do_start(1'b1);
    send_random(0);
    // mid-frame dir change is ignored for the current word
    for (int i = 0; i < N; i++) begin
      if (i == 3) dir = 0;
      bit_valid = 1; bit_in = 8'hB2 >> (N-1-i);
      if (i == N - 1) exp_q.push_back(8'h4D);
      tick();
    end
    bit_valid = 0;
    checks++; if (word_out !== 8'h4D) begin failures++; $display("FAIL right_word: got %h, required 4d", word_out); end
    tick();
    stop = 1; tick(); stop = 0;
  endtask

  task automatic test_overrun();
    word_ready = 0;
    do_start(1'b0);
    send_word(8'hB2, 1'b0, 1'b1);
    send_word(8'hFF, 1'b0, 1'b0);
    checks++; if (word_out !== 8'hB2) begin failures++; $display("FAIL ovr_word_held: got %h, required b2", word_out); end
    checks++; if (overrun !== 1) begin failures++; $display("FAIL ovr_set: got %b, required 1", overrun); end
    checks++; if (word_valid !== 1) begin failures++; $display("FAIL ovr_valid: got %b, required 1", word_valid); end
    clear_overrun = 1; tick(); clear_overrun = 0;
    checks++; if (overrun !== 0) begin failures++; $display("FAIL ovr_clear: got %b, required 0", overrun); end
    word_ready = 1; tick();
    checks++; if (word_valid !== 0) begin failures++; $display("FAIL ovr_drain: got %b, required 0", word_valid); end
    stop = 1; tick(); stop = 0;
  endtask

  task automatic test_restart_abort();
    word_ready = 1;
    do_start(1'b0);
    send_random(5);
    checks++; if (bit_count !== 3'd5) begin failures++; $display("FAIL rs_partial_count: got %0d, required 5", bit_count); end
    do_start(1'b0);
    send_word(8'h3C, 1'b0, 1'b1);
    checks++; if (word_out !== 8'h3C) begin failures++; $display("FAIL rs_word: got %h, required 3c", word_out); end
    send_random(3);
    stop = 1; tick(); stop = 0;
    checks++; if (busy !== 0) begin failures++; $display("FAIL abort_busy: got %b, required 0", busy); end
    checks++; if (bit_count !== '0) begin failures++; $display("FAIL abort_count: got %0d, required 0", bit_count); end
    checks++; if (word_valid !== 0) begin failures++; $display("FAIL abort_valid: got %b, required 0", word_valid); end
  endtask

  task automatic test_back_to_back();
    word_ready = 1;
    do_start(1'b0);
    send_word(8'h5A, 1'b0, 1'b1);
    dir = 1;                       // relatched at the boundary above? no: takes effect next boundary
    send_word(8'hC3, 1'b0, 1'b1);  // dir was 0 at the first boundary
    send_word(8'h81, 1'b1, 1'b1);  // dir was 1 at the second boundary
    checks++; if (word_out !== rev(8'h81)) begin failures++; $display("FAIL b2b_word: got %h, required %h", word_out, rev(8'h81)); end
    dir = 0;
    tick();
    stop = 1; tick(); stop = 0;
  endtask

  task automatic test_reset_mid();
    word_ready = 0;
    do_start(1'b0);
    send_word(8'h11, 1'b0, 1'b1);
    send_random(6);
    checks++; if (bit_count !== 3'd6) begin failures++; $display("FAIL rm_count: got %0d, required 6", bit_count); end
    checks++; if (word_valid !== 1) begin failures++; $display("FAIL rm_valid: got %b, required 1", word_valid); end
    reset = 1; exp_q.delete(); bit_valid = 1; bit_in = 1;
    tick();
    reset = 0; bit_valid = 0;
    checks++; if ({word_out, word_valid, overrun, busy, bit_count} !== '0) begin
      failures++;
      $display("FAIL rm_all_zero: got word_out=%h valid=%b ovr=%b busy=%b cnt=%0d, required all 0",
               word_out, word_valid, overrun, busy, bit_count);
    end
    word_ready = 1;
    do_start(1'b0);
    send_word(8'hA5, 1'b0, 1'b1);
    checks++; if (word_out !== 8'hA5) begin failures++; $display("FAIL rm_word: got %h, required a5", word_out); end
    tick();
  endtask

  initial begin
    idle_inputs(); dir = 0; word_ready = 0; reset = 1;
    test_reset();
    test_shift_left();
    test_shift_right();
    test_overrun();
    test_restart_abort();
    test_back_to_back();
    test_reset_mid();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d words never transferred, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_word_collector.md
SERIAL_WORD_COLLECTOR -- requirements
Module: serial_word_collector

Interface
REQ-001 Parameter N, default 4; word width in bits; the block SHALL reject or fail elaboration for N < 2.
REQ-002 Local width CW = $clog2(N) SHALL size bit_count.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  frame start pulse; clears partial frame and begins collection.
REQ-006 stop  input  1  abort; returns to IDLE and discards partial frame.
REQ-007 dir  input  1  0 = shift left (first bit ends in MSB); 1 = shift right (first bit ends in LSB).
REQ-008 bit_valid  input  1  bit_in is presented this cycle.
REQ-009 bit_in  input  1  serial data bit.
REQ-010 word_ready  input  1  downstream accepts word_out.
REQ-011 clear_overrun  input  1  clears sticky overrun flag.
REQ-012 word_out  output  N  assembled parallel word.
REQ-013 word_valid  output  1  word_out holds an unconsumed word.
REQ-014 overrun  output  1  sticky; a completed word was dropped.
REQ-015 busy  output  1  high in COLLECT.
REQ-016 bit_count  output  CW  bits accepted in current frame, 0..N-1.

Function
REQ-017 FSM SHALL have two states: IDLE and COLLECT.
REQ-018 IDLE -> COLLECT on start; COLLECT -> IDLE on stop; COLLECT SHALL otherwise persist across words (continuous framing).
REQ-019 Control priority SHALL be stop > start > bit_valid, in every state.
REQ-020 On start: shift register and bit_count cleared, dir latched for the frame; the bit_valid of that cycle SHALL be ignored.
REQ-021 dir SHALL be re-latched at every word boundary (bit_count wrap) and at every start; changes mid-frame SHALL have no effect.
REQ-022 A bit SHALL be accepted only when state is COLLECT, bit_valid = 1, start = 0, stop = 0.
REQ-023 Accepted bit, latched dir 0: sh <= {sh[N-2:0], bit_in}; latched dir 1: sh <= {bit_in, sh[N-1:1]}.
REQ-024 bit_count SHALL increment per accepted bit and wrap N-1 -> 0 on the Nth bit.
REQ-025 At the edge accepting the Nth bit, the completed word (including that bit) SHALL become available; latency 0 cycles after that edge.
REQ-026 Handshake: word transfers at an edge where word_valid = 1 and word_ready = 1; word_out SHALL remain stable while word_valid = 1 and word_ready = 0.
REQ-027 Completion with word_valid = 0, or coinciding with a transfer: word_out <= completed word, word_valid <= 1, no overrun.
REQ-028 Transfer with no completion: word_valid <= 0; word_out retains its value.
REQ-029 Completion with word_valid = 1 and word_ready = 0: new word dropped, word_out unchanged, overrun <= 1.
REQ-030 overrun SHALL stay 1 until clear_overrun or reset; simultaneous set and clear SHALL leave overrun = 1.
REQ-031 stop or start SHALL NOT affect word_out, word_valid or overrun; a pending word survives abort.
REQ-032 In IDLE the shift register and bit_count SHALL hold 0.

Reset
REQ-033 While reset = 1 at a clock edge: state IDLE, shift register 0, word_out 0, word_valid 0, overrun 0, busy 0, bit_count 0, latched dir 0.
REQ-034 Reset SHALL override all inputs, including mid-frame and with word_valid = 1; pending word discarded.

Verification (N = 8)
REQ-035 Reset: assert reset 2 cycles with random inputs -> all outputs 0, busy 0.
REQ-036 dir=0, start, then bits 1,0,1,1,0,0,1,0 with word_ready=1 -> word_out 8'hB2, word_valid high 1 cycle, bit_count back to 0.
REQ-037 dir=1, same sequence -> word_out 8'h4D.
REQ-038 word_ready=0, two full frames 8'hB2 then 8'hFF (dir=0) -> word_out stays 8'hB2, overrun 1; pulse clear_overrun -> overrun 0; word_ready=1 -> word_valid drops next edge.
REQ-039 5 bits, then start, then 8 bits 8'h3C -> word_out 8'h3C; 3 bits then stop -> busy 0, bit_count 0, no word_valid.
REQ-040 Reset asserted with bit_count 6 and word_valid 1 -> next edge all outputs 0; subsequent start and frame 8'hA5 collected correctly.
